union_find_controller: RTL and testbench
========================================

# union_find_controller

Initiator for the union-find parent-array memory system. Accepts FIND and UNION commands from the solver core and turns them into a sequence of single-outstanding find-read and union-write requests on the memory port, walking parent pointers to the root. Returns the root, a same-set flag and a read count. Sits between the solver front end and the parent-array memory system.

## Interface
- ADDR_W, 6, node index / parent-pointer width; must match the memory system.
- MAX_HOPS, 64, maximum find reads per single root walk before the walk aborts with an error.

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  high only in IDLE and not in reset; command accepted when cmd_valid && cmd_ready
- cmd_op  input  1  0 = FIND(a), 1 = UNION(a,b)
- cmd_a  input  ADDR_W  first node
- cmd_b  input  ADDR_W  second node; ignored for FIND
- res_valid  output  1  one-cycle result pulse
- res_root  output  ADDR_W  FIND: root of a; UNION: root of b (the surviving root)
- res_same  output  1  UNION only: a and b were already in one set, no write issued
- res_err  output  1  a walk exceeded MAX_HOPS; no write issued
- res_hops  output  8  total find reads issued for the command (saturates at 255)
- find_req  output  1  memory read request, one-cycle pulse
- find_addr  output  ADDR_W  read address
- find_data  input  ADDR_W  parent of find_addr
- find_ready  input  1  read data valid, one cycle after find_req
- union_req  output  1  memory write request, one-cycle pulse
- union_addr  output  ADDR_W  write address
- union_data  output  ADDR_W  new parent value
- union_ready  input  1  write complete, one cycle after union_req

## Operation
- States: IDLE, FA_REQ, FA_WAIT, FB_REQ, FB_WAIT, LINK_REQ, LINK_WAIT, DONE.
- IDLE: on accept, latch op/a/b, set cur = a, hops = 0, walk count = 0 -> FA_REQ.
- Fx_REQ: find_req = 1, find_addr = cur, hops++ and walk count++ -> Fx_WAIT.
- Fx_WAIT: hold until find_ready. If find_data == cur: root found. Else if walk count == MAX_HOPS: set err -> DONE. Else cur = find_data -> Fx_REQ.
- Root of A found: FIND -> root = cur -> DONE. UNION -> root_a = cur, cur = b, walk count = 0 -> FB_REQ.
- Root of B found: if root_b == root_a, set same -> DONE. Else -> LINK_REQ.
- LINK_REQ: union_req = 1, union_addr = root_a, union_data = root_b -> LINK_WAIT.
- LINK_WAIT: hold until union_ready -> DONE.
- DONE: res_valid = 1 for one cycle with res_root, res_same, res_err and res_hops -> IDLE.
- res_root: root_b for UNION, root_a for FIND, and the last cur on error.
- find_req and union_req are never high in the same cycle. At most one memory request is outstanding.
- find_ready and union_ready arriving in a state that is not waiting for them are ignored.
- cmd_valid while busy is ignored.
- res_* hold their values between pulses. They are sampled only on res_valid.

## Timing
- Reset: state = IDLE. All outputs 0, including cmd_ready during the reset cycle. cmd_ready = 1 in the first cycle after reset deasserts.
- Reset mid-command aborts the command immediately. No res_valid pulse is produced, and responses arriving afterwards are ignored.
- Command accepted at cycle T. The first find_req is at T+1.
- Each find read costs 2 cycles; a write costs 2 cycles.
- FIND with k parent links: res_valid at T+1+2(k+1).
- UNION with distinct roots: res_valid at T+1+2(ka+1)+2(kb+1)+2.
- UNION with the same root: as above without the +2 for the write.
- cmd_ready rises in the cycle after res_valid (IDLE).
- Memory latency greater than one cycle is tolerated: WAIT states hold indefinitely.

## Test plan
- After reset, FIND a=5 accepted at T -> one read of addr 5 at T+1; res_valid at T+3 with root=5, hops=1, same=0, err=0.
- UNION a=3, b=7 on a fresh array -> reads of 3 then 7, then write addr 3 <- 7; res_valid at T+7 with root=7, same=0, hops=2.
- Then UNION 7,12, then FIND 3 -> reads 3, 7, 12; root=12, hops=3, no union_req.
- Then UNION 3,12 -> reads 3, 7, 12, 12; res_same=1, root=12, union_req never asserted.
- MAX_HOPS=2 instance, chain 3->7->12 built as above, FIND 3 -> reads 3, 7 only; res_err=1, root=7, hops=2.
- Assert reset while in FA_WAIT, and drive find_ready one cycle later -> no res_valid, all outputs 0; cmd_ready=1 in the cycle after reset drops; the next FIND completes normally.

Source files
------------

// File: rtl/union_find_controller.sv
// Union-find command initiator: walks parent pointers to the root with one memory request
// outstanding at a time, links distinct roots on UNION, and reports root/same/err/hop count.
module union_find_controller #(
  parameter int ADDR_W   = 6,
  parameter int MAX_HOPS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_root,
  output logic              res_same,
  output logic              res_err,
  output logic [7:0]        res_hops,
  output logic              find_req,
  output logic [ADDR_W-1:0] find_addr,
  input  logic [ADDR_W-1:0] find_data,
  input  logic              find_ready,
  output logic              union_req,
  output logic [ADDR_W-1:0] union_addr,
  output logic [ADDR_W-1:0] union_data,
  input  logic              union_ready
);

  localparam int WALK_W = $clog2(MAX_HOPS + 1);

  typedef enum logic [2:0] {
    IDLE, FA_REQ, FA_WAIT, FB_REQ, FB_WAIT, LINK_REQ, LINK_WAIT, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                op_q, op_d;
  logic [ADDR_W-1:0]   b_q, b_d;
  logic [ADDR_W-1:0]   cur_q, cur_d;
  logic [ADDR_W-1:0]   root_a_q, root_a_d;
  logic [7:0]          hops_q, hops_d;
  logic [WALK_W-1:0]   walk_q, walk_d;
  logic [ADDR_W-1:0]   res_root_q, res_root_d;
  logic                res_same_q, res_same_d;
  logic                res_err_q, res_err_d;
  logic [7:0]          res_hops_q, res_hops_d;
  logic                finish, fin_same, fin_err;

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    b_d        = b_q;
    cur_d      = cur_q;
    root_a_d   = root_a_q;
    hops_d     = hops_q;
    walk_d     = walk_q;
    res_root_d = res_root_q;
    res_same_d = res_same_q;
    res_err_d  = res_err_q;
    res_hops_d = res_hops_q;
    finish     = 1'b0;
    fin_same   = 1'b0;
    fin_err    = 1'b0;

    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          op_d    = cmd_op;
          b_d     = cmd_b;
          cur_d   = cmd_a;
          hops_d  = '0;
          walk_d  = '0;
          state_d = FA_REQ;
        end
      end
      FA_REQ, FB_REQ: begin
        hops_d  = (hops_q == 8'hff) ? hops_q : hops_q + 8'd1;
        walk_d  = walk_q + 1'b1;
        state_d = (state_q == FA_REQ) ? FA_WAIT : FB_WAIT;
      end
      FA_WAIT, FB_WAIT: begin
        if (find_ready) begin
          if (find_data == cur_q) begin
            if (state_q == FA_WAIT && !op_q) begin
              finish = 1'b1;
            end else if (state_q == FA_WAIT) begin
              root_a_d = cur_q;
              cur_d    = b_q;
              walk_d   = '0;
              state_d  = FB_REQ;
            end else if (cur_q == root_a_q) begin
              finish   = 1'b1;
              fin_same = 1'b1;
            end else begin
              state_d = LINK_REQ;
            end
          end else if (walk_q == WALK_W'(MAX_HOPS)) begin
            finish  = 1'b1;
            fin_err = 1'b1;
          end else begin
            cur_d   = find_data;
            state_d = (state_q == FA_WAIT) ? FA_REQ : FB_REQ;
          end
        end
      end
      LINK_REQ:  state_d = LINK_WAIT;
      LINK_WAIT: if (union_ready) finish = 1'b1;
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    // Every terminating path leaves the reported root in cur (root, root_b or last walked node).
    if (finish) begin
      res_root_d = cur_q;
      res_same_d = fin_same;
      res_err_d  = fin_err;
      res_hops_d = hops_q;
      state_d    = DONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      op_q       <= 1'b0;
      b_q        <= '0;
      cur_q      <= '0;
      root_a_q   <= '0;
      hops_q     <= '0;
      walk_q     <= '0;
      res_root_q <= '0;
      res_same_q <= 1'b0;
      res_err_q  <= 1'b0;
      res_hops_q <= '0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      b_q        <= b_d;
      cur_q      <= cur_d;
      root_a_q   <= root_a_d;
      hops_q     <= hops_d;
      walk_q     <= walk_d;
      res_root_q <= res_root_d;
      res_same_q <= res_same_d;
      res_err_q  <= res_err_d;
      res_hops_q <= res_hops_d;
    end
  end

  assign cmd_ready  = !reset && (state_q == IDLE);
  assign res_valid  = !reset && (state_q == DONE);
  assign res_root   = reset ? '0 : res_root_q;
  assign res_same   = !reset && res_same_q;
  assign res_err    = !reset && res_err_q;
  assign res_hops   = reset ? '0 : res_hops_q;
  assign find_req   = !reset && (state_q == FA_REQ || state_q == FB_REQ);
  assign find_addr  = find_req ? cur_q : '0;
  assign union_req  = !reset && (state_q == LINK_REQ);
  assign union_addr = union_req ? root_a_q : '0;
  assign union_data = union_req ? cur_q : '0;

endmodule

// File: tb/tb_union_find_controller.sv
// Bench: two controllers (MAX_HOPS 64 and 2), each with a parent-array memory responder;
// directed table plus random commands checked against a path-list reference model.
module tb_union_find_controller;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         nvec = 0;
  int         nmis = 0;

  logic       rst       [2];
  logic       cmd_valid [2];
  logic       cmd_op    [2];
  logic [5:0] cmd_a     [2];
  logic [5:0] cmd_b     [2];
  int         lat_extra [2];

  logic       cmd_ready  [2];
  logic       res_valid  [2];
  logic [5:0] res_root   [2];
  logic       res_same   [2];
  logic       res_err    [2];
  logic [7:0] res_hops   [2];
  logic       find_req   [2];
  logic [5:0] find_addr  [2];
  logic       union_req  [2];
  logic [5:0] union_addr [2];
  logic [5:0] union_data [2];

  logic [5:0] model_par [2][64];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic       fr = 1'b0;
    logic       ur = 1'b0;
    logic [5:0] fd = '0;
    logic [5:0] mem [64];

    union_find_controller #(.ADDR_W(6), .MAX_HOPS(g == 0 ? 64 : 2)) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .cmd_valid  (cmd_valid[g]),
      .cmd_ready  (cmd_ready[g]),
      .cmd_op     (cmd_op[g]),
      .cmd_a      (cmd_a[g]),
      .cmd_b      (cmd_b[g]),
      .res_valid  (res_valid[g]),
      .res_root   (res_root[g]),
      .res_same   (res_same[g]),
      .res_err    (res_err[g]),
      .res_hops   (res_hops[g]),
      .find_req   (find_req[g]),
      .find_addr  (find_addr[g]),
      .find_data  (fd),
      .find_ready (fr),
      .union_req  (union_req[g]),
      .union_addr (union_addr[g]),
      .union_data (union_data[g]),
      .union_ready(ur)
    );

    // Parent-array memory: answers one cycle after a request plus lat_extra cycles.
    always begin
      logic [5:0] ad, wd;
      @(negedge clk);
      if (rst[g]) begin
        for (int i = 0; i < 64; i++) mem[i] = 6'(i);
      end else if (find_req[g]) begin
        ad = find_addr[g];
        @(posedge clk); #1;
        repeat (lat_extra[g]) begin @(posedge clk); #1; end
        fr = 1'b1; fd = mem[ad];
        @(posedge clk); #1;
        fr = 1'b0;
      end else if (union_req[g]) begin
        ad = union_addr[g]; wd = union_data[g];
        @(posedge clk); #1;
        repeat (lat_extra[g]) begin @(posedge clk); #1; end
        ur = 1'b1; mem[ad] = wd;
        @(posedge clk); #1;
        ur = 1'b0;
      end
    end
  end

  task automatic check(input string name, input longint act, input longint exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: list the path from x to its root, then apply the hop limit to that list.
  task automatic walk(input int g, input logic [5:0] x, output logic [5:0] root,
                      output int reads, output bit err);
    logic [5:0] path[$];
    int maxh = (g == 0) ? 64 : 2;
    int k;
    path.push_back(x);
    while (model_par[g][path[path.size()-1]] != path[path.size()-1] && path.size() < 80)
      path.push_back(model_par[g][path[path.size()-1]]);
    k = path.size() - 1;
    if (k + 1 <= maxh) begin
      root = path[k]; reads = k + 1; err = 1'b0;
    end else begin
      root = path[maxh-1]; reads = maxh; err = 1'b1;
    end
  endtask

  task automatic model(input int g, input bit op, input logic [5:0] a, input logic [5:0] b,
                       output logic [5:0] root, output bit same, output bit err,
                       output int hops, output int wr, output logic [5:0] wa);
    logic [5:0] ra, rb;
    int ha, hb;
    bit ea, eb;
    walk(g, a, ra, ha, ea);
    same = 1'b0; wr = 0; wa = ra;
    if (!op || ea) begin
      root = ra; err = ea; hops = ha;
    end else begin
      walk(g, b, rb, hb, eb);
      root = rb; err = eb; hops = ha + hb;
      same = !eb && (rb == ra);
      if (!eb && rb != ra) begin
        wr = 1;
        model_par[g][ra] = rb;
      end
    end
  endtask

  task automatic run_cmd(input int g, input bit op, input logic [5:0] a, input logic [5:0] b,
                         output logic [5:0] root, output bit same, output bit err,
                         output int hops, output int lat, output int nrd, output int nwr,
                         output logic [5:0] wa, output logic [5:0] wd);
    int t0;
    bit tmo;
    root = '0; same = 0; err = 0; hops = 0; lat = 0; nrd = 0; nwr = 0; wa = '0; wd = '0;
    tmo = 1'b1;
    @(posedge clk); #1;
    cmd_valid[g] = 1'b1; cmd_op[g] = op; cmd_a[g] = a; cmd_b[g] = b;
    t0 = cyc;
    @(posedge clk); #1;
    cmd_valid[g] = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (find_req[g]) nrd++;
      if (union_req[g]) begin
        nwr++; wa = union_addr[g]; wd = union_data[g];
      end
      if (res_valid[g]) begin
        root = res_root[g]; same = res_same[g]; err = res_err[g]; hops = int'(res_hops[g]);
        lat = cyc - t0; tmo = 1'b0;
        break;
      end
    end
    if (tmo) check("res_valid_timeout", 1, 0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst[0] = 1'b1; rst[1] = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    for (int g = 0; g < 2; g++)
      for (int i = 0; i < 64; i++) model_par[g][i] = 6'(i);
  endtask

  typedef struct {
    int g; int op; int a; int b;
    int root; int same; int err; int hops; int lat; int wr; int wa;
  } vec_t;

  vec_t tbl [10];

  initial begin
    logic [5:0] root, wa, wd, e_root, e_wa;
    bit same, err, e_same, e_err;
    int hops, lat, nrd, nwr, e_hops, e_wr, lx, g;
    bit op;
    logic [5:0] a, b;

    //            g op  a   b  root same err hops lat wr wa
    tbl[0] = '{0, 0,  5,  0,  5,  0,  0,  1,  3, 0, 0};
    tbl[1] = '{0, 1,  3,  7,  7,  0,  0,  2,  7, 1, 3};
    tbl[2] = '{0, 1,  7, 12, 12,  0,  0,  2,  7, 1, 7};
    tbl[3] = '{0, 0,  3,  0, 12,  0,  0,  3,  7, 0, 0};
    tbl[4] = '{0, 1,  3, 12, 12,  1,  0,  4,  9, 0, 0};
    tbl[5] = '{1, 1,  3,  7,  7,  0,  0,  2,  7, 1, 3};
    tbl[6] = '{1, 1,  7, 12, 12,  0,  0,  2,  7, 1, 7};
    tbl[7] = '{1, 0,  3,  0,  7,  0,  1,  2,  5, 0, 0};
    tbl[8] = '{1, 0, 12,  0, 12,  0,  0,  1,  3, 0, 0};
    tbl[9] = '{1, 1,  3, 20,  7,  0,  1,  2,  5, 0, 0};

    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; cmd_valid[i] = 1'b0; cmd_op[i] = 1'b0;
      cmd_a[i] = '0; cmd_b[i] = '0; lat_extra[i] = 0;
    end

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("cmd_ready_in_reset", cmd_ready[0], 0);
    check("res_valid_in_reset", res_valid[1], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready[0], 1);
    check("cmd_ready_after_reset_1", cmd_ready[1], 1);
    check("find_req_after_reset", find_req[0], 0);
    check("union_req_after_reset", union_req[0], 0);
    check("res_root_after_reset", res_root[0], 0);
    check("res_hops_after_reset", res_hops[0], 0);

    // Directed table: test-plan sequences on both instances.
    for (int i = 0; i < 10; i++) begin
      run_cmd(tbl[i].g, tbl[i].op[0], 6'(tbl[i].a), 6'(tbl[i].b),
              root, same, err, hops, lat, nrd, nwr, wa, wd);
      check($sformatf("tbl%0d_root", i), root, tbl[i].root);
      check($sformatf("tbl%0d_same", i), same, tbl[i].same);
      check($sformatf("tbl%0d_err", i), err, tbl[i].err);
      check($sformatf("tbl%0d_hops", i), hops, tbl[i].hops);
      check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
      check($sformatf("tbl%0d_reads", i), nrd, tbl[i].hops);
      check($sformatf("tbl%0d_writes", i), nwr, tbl[i].wr);
      if (tbl[i].wr != 0) begin
        check($sformatf("tbl%0d_waddr", i), wa, tbl[i].wa);
        check($sformatf("tbl%0d_wdata", i), wd, tbl[i].root);
      end
    end

    // Reset while waiting for a read; the late read response must be ignored.
    do_reset();
    lat_extra[0] = 1;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b1; cmd_op[0] = 1'b0; cmd_a[0] = 6'd9;
    @(posedge clk); #1;
    cmd_valid[0] = 1'b0;
    @(negedge clk);
    check("abort_find_req", find_req[0], 1);
    check("abort_find_addr", find_addr[0], 9);
    @(posedge clk); #1;
    rst[0] = 1'b1;
    @(negedge clk);
    check("abort_cmd_ready_in_reset", cmd_ready[0], 0);
    check("abort_find_req_in_reset", find_req[0], 0);
    check("abort_find_addr_in_reset", find_addr[0], 0);
    check("abort_res_valid_in_reset", res_valid[0], 0);
    @(posedge clk); #1;
    rst[0] = 1'b0;
    @(negedge clk);
    check("abort_cmd_ready_after", cmd_ready[0], 1);
    nwr = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (res_valid[0] || find_req[0] || union_req[0] || !cmd_ready[0]) nwr++;
    end
    check("abort_quiet_cycles", nwr, 0);
    lat_extra[0] = 0;
    run_cmd(0, 1'b0, 6'd9, 6'd0, root, same, err, hops, lat, nrd, nwr, wa, wd);
    check("post_abort_root", root, 9);
    check("post_abort_hops", hops, 1);
    check("post_abort_latency", lat, 3);

    // Random commands against the reference model, with random memory latency.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      g  = (n < 300) ? 0 : 1;
      op = ($urandom_range(0, 2) != 0);
      if (g == 1)
        begin a = 6'($urandom_range(0, 7));  b = 6'($urandom_range(0, 7)); end
      else if (n < 150)
        begin a = 6'($urandom_range(0, 15)); b = 6'($urandom_range(0, 15)); end
      else
        begin a = 6'($urandom_range(0, 63)); b = 6'($urandom_range(0, 63)); end
      lx = $urandom_range(0, 2);
      lat_extra[g] = lx;
      model(g, op, a, b, e_root, e_same, e_err, e_hops, e_wr, e_wa);
      run_cmd(g, op, a, b, root, same, err, hops, lat, nrd, nwr, wa, wd);
      check($sformatf("rnd%0d_root", n), root, e_root);
      check($sformatf("rnd%0d_same", n), same, e_same);
      check($sformatf("rnd%0d_err", n), err, e_err);
      check($sformatf("rnd%0d_hops", n), hops, e_hops);
      check($sformatf("rnd%0d_reads", n), nrd, e_hops);
      check($sformatf("rnd%0d_writes", n), nwr, e_wr);
      check($sformatf("rnd%0d_latency", n), lat, 1 + (2 + lx) * (e_hops + e_wr));
      if (e_wr != 0) begin
        check($sformatf("rnd%0d_waddr", n), wa, e_wa);
        check($sformatf("rnd%0d_wdata", n), wd, e_root);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
